// File: rtl/s_core_boot_ctrl_if.sv
// Command stream link between the host/debug side and the s_core boot sequencer.
interface s_core_boot_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/s_core_boot_ctrl.sv
// s_core setup/run sequencer: decodes a 32-bit command stream into imem and
// register-file writes, loads the start PC, releases the core and supervises the run.
// Optional feature macro: BOOT_CKSUM_EN (START carries an XOR checksum of loaded imem words).
module s_core_boot_ctrl #(
  parameter int unsigned MAX_RUN_CYCLES = 0,
  parameter int unsigned RUN_CNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  s_core_boot_ctrl_if.slave   cmd,
  output logic                o_setup,
  output logic                o_imem_we,
  output logic [31:0]         o_inst_mem_addr,
  output logic [31:0]         o_inst_mem_data,
  output logic                o_reg_we,
  output logic [4:0]          o_load_reg_addr,
  output logic [31:0]         o_load_reg_data,
  output logic [31:0]         o_pc_instr_start_addr,
  output logic                o_running,
  output logic                o_done,
  output logic                o_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned REG_W  = 5;

  localparam logic [3:0] OP_IMEM  = 4'h1;
  localparam logic [3:0] OP_REG   = 4'h2;
  localparam logic [3:0] OP_START = 4'h3;
  localparam logic [3:0] OP_STOP  = 4'h4;

  localparam logic [RUN_CNT_W-1:0] RUN_LIMIT = RUN_CNT_W'(MAX_RUN_CYCLES - 1);
  localparam logic                 LIMIT_EN  = (MAX_RUN_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE, IM_ADDR, IM_DATA, RG_DATA, PC_WORD,
`ifdef BOOT_CKSUM_EN
    CK_WORD,
`endif
    RELEASE, RUN
  } state_t;

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]    addr_q, addr_d;
  logic [REG_W-1:0]     rd_q, rd_d;
  logic [RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic                 setup_d, imem_we_d, reg_we_d, running_d, done_d, err_d;
  logic [DATA_W-1:0]    imem_addr_d, imem_data_d, reg_data_d, pc_d;
  logic [REG_W-1:0]     reg_addr_d;
`ifdef BOOT_CKSUM_EN
  logic [DATA_W-1:0]    cksum_q, cksum_d;
`endif

  logic       accept;
  logic [3:0] op;
  logic       limit_hit;

  assign accept      = cmd.s_valid & ready_q;
  assign op          = cmd.s_data[31:28];
  assign limit_hit   = LIMIT_EN && (run_cnt_q == RUN_LIMIT);
  assign cmd.s_ready = ready_q;

  // Next-state and next-output decode; strobes default low, payload registers hold.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    run_cnt_d   = run_cnt_q;
    setup_d     = o_setup;
    running_d   = o_running;
    imem_we_d   = 1'b0;
    reg_we_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = o_err;
    imem_addr_d = o_inst_mem_addr;
    imem_data_d = o_inst_mem_data;
    reg_addr_d  = o_load_reg_addr;
    reg_data_d  = o_load_reg_data;
    pc_d        = o_pc_instr_start_addr;
`ifdef BOOT_CKSUM_EN
    cksum_d     = cksum_q;
`endif
    unique case (state_q)
      IDLE: if (accept) begin
        unique case (op)
          OP_IMEM: begin
            cnt_d   = cmd.s_data[CNT_W-1:0];
            state_d = IM_ADDR;
          end
          OP_REG: begin
            rd_d    = cmd.s_data[REG_W-1:0];
            state_d = RG_DATA;
          end
          OP_START: state_d = PC_WORD;
          default:  err_d   = 1'b1;
        endcase
      end
      IM_ADDR: if (accept) begin
        addr_d  = cmd.s_data;
        state_d = (cnt_q == CNT_W'(0)) ? IDLE : IM_DATA;
      end
      IM_DATA: if (accept) begin
        imem_we_d   = 1'b1;
        imem_addr_d = addr_q;
        imem_data_d = cmd.s_data;
        addr_d      = addr_q + DATA_W'(4);
        cnt_d       = cnt_q - CNT_W'(1);
`ifdef BOOT_CKSUM_EN
        cksum_d     = cksum_q ^ cmd.s_data;
`endif
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      RG_DATA: if (accept) begin
        reg_we_d   = 1'b1;
        reg_addr_d = rd_q;
        reg_data_d = cmd.s_data;
        state_d    = IDLE;
      end
      PC_WORD: if (accept) begin
        pc_d = cmd.s_data;
`ifdef BOOT_CKSUM_EN
        state_d = CK_WORD;
`else
        state_d = RELEASE;
`endif
      end
`ifdef BOOT_CKSUM_EN
      CK_WORD: if (accept) begin
        cksum_d = '0;
        if (cmd.s_data == cksum_q) begin
          state_d = RELEASE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      RELEASE: begin
        setup_d   = 1'b0;
        running_d = 1'b1;
        run_cnt_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
        if (accept && op != OP_STOP) err_d = 1'b1;
        if ((accept && op == OP_STOP) || limit_hit) begin
          setup_d   = 1'b1;
          running_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != RELEASE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q               <= IDLE;
      ready_q               <= 1'b0;
      cnt_q                 <= '0;
      addr_q                <= '0;
      rd_q                  <= '0;
      run_cnt_q             <= '0;
      o_setup               <= 1'b1;
      o_running             <= 1'b0;
      o_imem_we             <= 1'b0;
      o_reg_we              <= 1'b0;
      o_done                <= 1'b0;
      o_err                 <= 1'b0;
      o_inst_mem_addr       <= '0;
      o_inst_mem_data       <= '0;
      o_load_reg_addr       <= '0;
      o_load_reg_data       <= '0;
      o_pc_instr_start_addr <= '0;
`ifdef BOOT_CKSUM_EN
      cksum_q               <= '0;
`endif
    end else begin
      state_q               <= state_d;
      ready_q               <= ready_d;
      cnt_q                 <= cnt_d;
      addr_q                <= addr_d;
      rd_q                  <= rd_d;
      run_cnt_q             <= run_cnt_d;
      o_setup               <= setup_d;
      o_running             <= running_d;
      o_imem_we             <= imem_we_d;
      o_reg_we              <= reg_we_d;
      o_done                <= done_d;
      o_err                 <= err_d;
      o_inst_mem_addr       <= imem_addr_d;
      o_inst_mem_data       <= imem_data_d;
      o_load_reg_addr       <= reg_addr_d;
      o_load_reg_data       <= reg_data_d;
      o_pc_instr_start_addr <= pc_d;
`ifdef BOOT_CKSUM_EN
      cksum_q               <= cksum_d;
`endif
    end
  end

endmodule

// File: tb/tb_s_core_boot_ctrl.sv
// Directed bench for s_core_boot_ctrl: unlimited-run instance (a) and 10-cycle-limit instance (b).
module tb_s_core_boot_ctrl;

  typedef struct packed {
    logic        is_reg;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq [$];
  logic [31:0] cks [2];

  always #5 clk = ~clk;

  s_core_boot_ctrl_if ifa ();
  s_core_boot_ctrl_if ifb ();

  logic a_setup, a_imem_we, a_reg_we, a_running, a_done, a_err;
  logic b_setup, b_imem_we, b_reg_we, b_running, b_done, b_err;
  logic [31:0] a_imem_addr, a_imem_data, a_reg_data, a_pc;
  logic [31:0] b_imem_addr, b_imem_data, b_reg_data, b_pc;
  logic [4:0]  a_reg_addr, b_reg_addr;

  s_core_boot_ctrl #(.MAX_RUN_CYCLES(0), .RUN_CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd(ifa.slave),
    .o_setup(a_setup), .o_imem_we(a_imem_we), .o_inst_mem_addr(a_imem_addr),
    .o_inst_mem_data(a_imem_data), .o_reg_we(a_reg_we), .o_load_reg_addr(a_reg_addr),
    .o_load_reg_data(a_reg_data), .o_pc_instr_start_addr(a_pc), .o_running(a_running),
    .o_done(a_done), .o_err(a_err)
  );

  s_core_boot_ctrl #(.MAX_RUN_CYCLES(10), .RUN_CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd(ifb.slave),
    .o_setup(b_setup), .o_imem_we(b_imem_we), .o_inst_mem_addr(b_imem_addr),
    .o_inst_mem_data(b_imem_data), .o_reg_we(b_reg_we), .o_load_reg_addr(b_reg_addr),
    .o_load_reg_data(b_reg_data), .o_pc_instr_start_addr(b_pc), .o_running(b_running),
    .o_done(b_done), .o_err(b_err)
  );

  // Outputs of whichever instance is currently under stimulus.
  wire        m_ready     = sel ? ifb.s_ready : ifa.s_ready;
  wire        m_setup     = sel ? b_setup     : a_setup;
  wire        m_imem_we   = sel ? b_imem_we   : a_imem_we;
  wire        m_reg_we    = sel ? b_reg_we    : a_reg_we;
  wire        m_running   = sel ? b_running   : a_running;
  wire        m_done      = sel ? b_done      : a_done;
  wire        m_err       = sel ? b_err       : a_err;
  wire [31:0] m_imem_addr = sel ? b_imem_addr : a_imem_addr;
  wire [31:0] m_imem_data = sel ? b_imem_data : a_imem_data;
  wire [31:0] m_reg_data  = sel ? b_reg_data  : a_reg_data;
  wire [31:0] m_pc        = sel ? b_pc        : a_pc;
  wire [4:0]  m_reg_addr  = sel ? b_reg_addr  : a_reg_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    ifa.s_valid = v & ~sel;
    ifb.s_valid = v & sel;
    ifa.s_data  = d;
    ifb.s_data  = d;
  endtask

  // Pops the write expected for this cycle, or expects no strobe at all.
  task automatic observe();
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk("imem_we", 32'(m_imem_we), 32'(!e.is_reg));
      chk("reg_we", 32'(m_reg_we), 32'(e.is_reg));
      if (e.is_reg) begin
        chk("reg_addr", 32'(m_reg_addr), e.addr);
        chk("reg_data", m_reg_data, e.data);
      end else begin
        chk("imem_addr", m_imem_addr, e.addr);
        chk("imem_data", m_imem_data, e.data);
      end
    end else begin
      chk("imem_we_quiet", 32'(m_imem_we), 32'd0);
      chk("reg_we_quiet", 32'(m_reg_we), 32'd0);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic push, input logic is_reg,
                      input logic [31:0] addr);
    logic r;
    int   n;
    n = 0;
    drive(1'b1, w);
    forever begin
      r = m_ready;
      @(posedge clk); #1;
      if (r) begin
        if (push) sbq.push_back('{is_reg, addr, w});
        observe();
        break;
      end
      observe();
      n++;
      if (n >= 50) begin
        chk("send_timeout_ready", 32'(r), 32'd1);
        break;
      end
    end
    drive(1'b0, 32'h0);
  endtask

  task automatic send_im(input logic [31:0] w, input logic [31:0] addr);
    cks[sel] = cks[sel] ^ w;
    send(w, 1'b1, 1'b0, addr);
  endtask

  task automatic start(input logic [31:0] pc);
    send(32'h3000_0000, 1'b0, 1'b0, 32'h0);
`ifdef BOOT_CKSUM_EN
    send(pc, 1'b0, 1'b0, 32'h0);
    send(cks[sel], 1'b0, 1'b0, 32'h0);
    cks[sel] = 32'h0;
`else
    send(pc, 1'b0, 1'b0, 32'h0);
`endif
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      observe();
    end
  endtask

  initial begin
    int run_len;
    logic done_seen;
    sel = 1'b0;
    cks[0] = 32'h0;
    cks[1] = 32'h0;
    ifa.s_valid = 1'b0; ifa.s_data = 32'h0;
    ifb.s_valid = 1'b0; ifb.s_data = 32'h0;
    rst_n = 1'b0;

    // Reset values
    #12;
    chk("rst_setup", 32'(a_setup), 32'd1);
    chk("rst_imem_we", 32'(a_imem_we), 32'd0);
    chk("rst_reg_we", 32'(a_reg_we), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_ready", 32'(ifa.s_ready), 32'd0);
    chk("rst_running", 32'(a_running), 32'd0);
    chk("rst_pc", a_pc, 32'h0);
    chk("rst_b_setup", 32'(b_setup), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(ifa.s_ready), 32'd1);
    chk("ready_after_rst_b", 32'(ifb.s_ready), 32'd1);

    // IMEM n=3 at 0x4, back-to-back
    send(32'h1000_0003, 1'b0, 1'b0, 32'h0);
    send(32'h0000_0004, 1'b0, 1'b0, 32'h0);
    send_im(32'h0012_7413, 32'h0000_0004);
    send_im(32'h0062_0033, 32'h0000_0008);
    send_im(32'h800a_a937, 32'h0000_000C);
    idle(2);

    // IMEM n=0 then REG rd=6, REG rd=0
    send(32'h1000_0000, 1'b0, 1'b0, 32'h0);
    send(32'h0000_0200, 1'b0, 1'b0, 32'h0);
    send(32'h2000_0006, 1'b0, 1'b0, 32'h0);
    send(32'h0000_0001, 1'b1, 1'b1, 32'd6);
    send(32'h2000_0000, 1'b0, 1'b0, 32'h0);
    send(32'hDEAD_BEEF, 1'b1, 1'b1, 32'd0);
    idle(1);

    // IMEM address wrap
    send(32'h1000_0002, 1'b0, 1'b0, 32'h0);
    send(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    send_im(32'h1111_2222, 32'hFFFF_FFFC);
    send_im(32'h3333_4444, 32'h0000_0000);
    idle(1);
    chk("no_err_after_loads", 32'(m_err), 32'd0);

    // START pc=0x4, unlimited run, REG header during run, STOP
    start(32'h0000_0004);
    chk("release_pc", m_pc, 32'h0000_0004);
    chk("release_setup", 32'(m_setup), 32'd1);
    chk("release_ready", 32'(m_ready), 32'd0);
    idle(1);
    chk("run_setup", 32'(m_setup), 32'd0);
    chk("run_running", 32'(m_running), 32'd1);
    chk("run_ready", 32'(m_ready), 32'd1);
    idle(47);
    send(32'h2000_0001, 1'b0, 1'b0, 32'h0);
    chk("run_bad_op_err", 32'(m_err), 32'd1);
    chk("run_bad_op_setup", 32'(m_setup), 32'd0);
    send(32'h4000_0000, 1'b0, 1'b0, 32'h0);
    chk("stop_done", 32'(m_done), 32'd1);
    chk("stop_setup", 32'(m_setup), 32'd1);
    chk("stop_running", 32'(m_running), 32'd0);
    idle(1);
    chk("stop_done_pulse", 32'(m_done), 32'd0);
    chk("err_sticky", 32'(m_err), 32'd1);

    // Limit instance: exactly 10 run cycles
    sel = 1'b1;
    drive(1'b0, 32'h0);
    start(32'h0000_0100);
    chk("lim_release_pc", m_pc, 32'h0000_0100);
    chk("lim_release_setup", 32'(m_setup), 32'd1);
    run_len = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      observe();
      if (m_setup) begin
        done_seen = m_done;
        break;
      end
      run_len++;
    end
    chk("lim_run_len", 32'(run_len), 32'd10);
    chk("lim_done", 32'(done_seen), 32'd1);
    idle(1);
    chk("lim_done_pulse", 32'(m_done), 32'd0);
    chk("lim_ready", 32'(m_ready), 32'd1);
    chk("lim_no_err", 32'(m_err), 32'd0);

`ifdef BOOT_CKSUM_EN
    // Wrong checksum: no release
    send(32'h3000_0000, 1'b0, 1'b0, 32'h0);
    send(32'h0000_0008, 1'b0, 1'b0, 32'h0);
    send(cks[1] ^ 32'h1, 1'b0, 1'b0, 32'h0);
    cks[1] = 32'h0;
    idle(3);
    chk("cksum_err", 32'(m_err), 32'd1);
    chk("cksum_setup", 32'(m_setup), 32'd1);
    chk("cksum_ready", 32'(m_ready), 32'd1);
`endif

    // Reset in the middle of a 4-word IMEM load on instance a
    sel = 1'b0;
    send(32'h1000_0004, 1'b0, 1'b0, 32'h0);
    send(32'h0000_1000, 1'b0, 1'b0, 32'h0);
    send_im(32'hAAAA_0001, 32'h0000_1000);
    send_im(32'hAAAA_0002, 32'h0000_1004);
    drive(1'b1, 32'hAAAA_0003);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_setup", 32'(a_setup), 32'd1);
    chk("midrst_imem_we", 32'(a_imem_we), 32'd0);
    chk("midrst_imem_addr", a_imem_addr, 32'h0);
    chk("midrst_err", 32'(a_err), 32'd0);
    chk("midrst_ready", 32'(ifa.s_ready), 32'd0);
    chk("midrst_pc", a_pc, 32'h0);
    chk("midrst_b_err", 32'(b_err), 32'd0);
    sbq.delete();
    cks[0] = 32'h0;
    cks[1] = 32'h0;
    drive(1'b0, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // Illegal op in IDLE: sticky error, stays in setup
    send(32'hF000_0000, 1'b0, 1'b0, 32'h0);
    chk("illegal_err", 32'(m_err), 32'd1);
    idle(3);
    chk("illegal_err_sticky", 32'(m_err), 32'd1);
    chk("illegal_setup", 32'(m_setup), 32'd1);
    chk("illegal_ready", 32'(m_ready), 32'd1);

    // STOP outside RUN on instance b
    sel = 1'b1;
    drive(1'b0, 32'h0);
    send(32'h4000_0000, 1'b0, 1'b0, 32'h0);
    chk("idle_stop_err", 32'(m_err), 32'd1);
    chk("idle_stop_done", 32'(m_done), 32'd0);
    chk("idle_stop_setup", 32'(m_setup), 32'd1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
